pusch_bit_deinterleaver: RTL and testbench
==========================================

# pusch_bit_deinterleaver

Receive-side inverse of the PUSCH bit interleaver (38.212 §6.3.2.4 / 5.4.2.2). It accepts one codeword of E soft bits (LLRs) in interleaved order, buffers them in a single-port-per-side RAM at de-interleaved addresses, then streams them out in original order e0..e(E-1). The block sits between the demapper/descrambler and the rate-dematching stage, one codeword at a time.

## Interface
- LLR_W, 8, LLR width in bits (signed, passed through untouched)
- MAX_E, 94000, buffer depth; maximum accepted E
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; sampled only in IDLE; latches E and Qm
- E  in  17  codeword length in soft bits
- Qm  in  3  modulation order; legal values 1, 2, 4, 6
- in_valid  in  1  in_llr valid
- in_llr  in  LLR_W  interleaved soft bit f(k)
- in_ready  out  1  block accepts in_llr this cycle
- out_valid  out  1  out_llr valid (no backpressure)
- out_llr  out  LLR_W  de-interleaved soft bit e(n)
- out_last  out  1  high with e(E-1)
- busy  out  1  high in any state except IDLE
- err  out  1  one-cycle pulse: illegal configuration, codeword rejected

## Operation
- States: IDLE, DIV, WRITE, READ.
- IDLE: start=1 latches E, Qm -> DIV. start in other states ignored.
- Qm not in {1,2,4,6} or E=0 or E>MAX_E: at the start edge, err pulses next cycle, stay IDLE.
- DIV: 17-iteration restoring divider computes R=E/Qm and remainder, one bit per cycle, exactly 17 cycles. Remainder≠0 -> err pulse, IDLE. Else -> WRITE.
- WRITE: in_ready=1. Input index k decomposes as k=i+j·Qm (i=0..Qm-1, j=0..R-1). Write address = i·R+j, generated incrementally without a multiplier: on each accepted bit, if i<Qm-1 then i++, addr+=R; else i=0, j++, addr=j (new j). Accept on in_valid&in_ready; gaps in in_valid simply stall. After the E-th accepted bit -> READ; in_ready low from the next cycle.
- READ: read address n=0..E-1, one per cycle, unconditionally; synchronous RAM, data registered to out_llr. out_last with n=E-1. After last output -> IDLE.
- Address widths: 17 bits; addr+R never exceeds E-1 by construction (Qm·R=E).

## Timing
- Reset values: in_ready=0, out_valid=0, out_llr=0, out_last=0, busy=0, err=0; state IDLE, counters 0. RAM contents undefined, never read before written.
- start sampled at cycle 0 (legal Qm, E): busy=1 from cycle 1; DIV occupies cycles 1..17; in_ready=1 from cycle 18, or err=1 in cycle 18 if E mod Qm≠0.
- Illegal Qm/E at cycle 0: err=1 in cycle 1, busy stays 0.
- Last input accepted at cycle w: READ issues address 0 at cycle w+1; out_valid=1 cycles w+2..w+E+1 contiguous; out_last at cycle w+E+1; busy=0 at cycle w+E+2; new start accepted from that cycle.
- Reset asserted mid-operation (any state): outputs return to reset values immediately; partial codeword discarded; next start begins clean.
- out_valid and in_ready never high in the same cycle.

## Test plan
- Qm=2, E=8, in_llr=0,1,..,7 back-to-back -> out_llr=0,2,4,6,1,3,5,7; out_last on 7th value; in_ready first high 18 cycles after start.
- Qm=6, E=12, in_llr=0..11 with in_valid dropped every other cycle -> out_llr=0,6,1,7,2,8,3,9,4,10,5,11, out_valid contiguous 12 cycles.
- Qm=1, E=5, in_llr=-3,7,0,127,-128 -> identical sequence out, out_last with -128.
- Qm=3, E=12 -> err pulse cycle 1, busy never high; Qm=4, E=10 -> err pulse cycle 18, in_ready never high.
- Qm=4, E=16, reset asserted after 9 accepted inputs -> all outputs 0 immediately; then new start with Qm=4, E=16, inputs 0..15 -> out 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
- Qm=6, E=MAX_E random LLRs -> output equals software model e(i·R+j)=f(i+j·6); start pulses during DIV/WRITE/READ ignored.

Source files
------------

// File: rtl/pusch_bit_deinterleaver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pusch_bit_deinterleaver
//
// Receive-side inverse of the PUSCH bit interleaver. One codeword of E soft
// bits arrives in interleaved order f(k). Each bit is written to its
// de-interleaved address. The buffer is then read out in natural order
// e(0)..e(E-1).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   start      one-cycle pulse, sampled only in IDLE; latches E and Qm
//   E          codeword length in soft bits (1..MAX_E)
//   Qm         modulation order (1, 2, 4 or 6)
//   in_valid   in_llr valid
//   in_llr     interleaved soft bit f(k)
//   in_ready   block accepts in_llr this cycle
//   out_valid  out_llr valid (no backpressure)
//   out_llr    de-interleaved soft bit e(n)
//   out_last   high with e(E-1)
//   busy       high in any state except IDLE
//   err        one-cycle pulse: illegal configuration, codeword rejected
// -----------------------------------------------------------------------------
module pusch_bit_deinterleaver #(
    parameter int LLR_W = 8,
    parameter int MAX_E = 94000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [16:0]      E,
    input  logic [2:0]       Qm,
    input  logic             in_valid,
    input  logic [LLR_W-1:0] in_llr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [LLR_W-1:0] out_llr,
    output logic             out_last,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    // Legal modulation orders.
    function automatic logic qm_legal(input logic [2:0] qm);
        logic ok;
        case (qm)
            3'd1, 3'd2, 3'd4, 3'd6: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t             state_r;
    state_t             next_state_s;

    logic [16:0]        e_r;
    logic [2:0]         qm_r;
    logic [16:0]        quot_r;

    // Restoring divider: div_q_r starts as the dividend and fills with
    // quotient bits from the LSB side as the dividend bits shift out.
    logic [16:0]        div_q_r;
    logic [2:0]         div_rem_r;
    logic [4:0]         div_cnt_r;

    logic [2:0]         wr_i_r;
    logic [16:0]        wr_j_r;
    logic [16:0]        wr_addr_r;
    logic [16:0]        wr_cnt_r;

    logic [16:0]        rd_addr_r;
    logic               rd_done_r;

    logic               in_ready_r;
    logic               out_valid_r;
    logic [LLR_W-1:0]   out_llr_r;
    logic               out_last_r;
    logic               busy_r;
    logic               err_r;

    logic [LLR_W-1:0]   mem [0:MAX_E-1];

    logic               cfg_ok_s;
    logic [3:0]         trial_s;
    logic               ge_s;
    logic [2:0]         rem_next_s;
    logic [16:0]        q_next_s;
    logic               div_last_s;
    logic               wr_fire_s;
    logic               wr_last_s;
    logic               rd_en_s;

    // Datapath decode: config check, divider step, write/read enables.
    always_comb begin
        cfg_ok_s   = qm_legal(Qm) && (E != 17'd0) && (E <= 17'(MAX_E));
        // Remainder is always < Qm <= 6, so three bits plus the incoming
        // dividend bit are enough for the trial value.
        trial_s    = {div_rem_r, div_q_r[16]};
        ge_s       = (trial_s >= {1'b0, qm_r});
        if (ge_s) begin
            rem_next_s = 3'(trial_s - {1'b0, qm_r});
        end else begin
            rem_next_s = trial_s[2:0];
        end
        q_next_s   = {div_q_r[15:0], ge_s};
        div_last_s = (div_cnt_r == 5'd16);
        wr_fire_s  = (state_r == ST_WRITE) && in_valid && in_ready_r;
        wr_last_s  = (wr_cnt_r == (e_r - 17'd1));
        rd_en_s    = (state_r == ST_READ) && !rd_done_r;
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && cfg_ok_s) begin
                    next_state_s = ST_DIV;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (!div_last_s) begin
                    next_state_s = ST_DIV;
                end else if (rem_next_s != 3'd0) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_fire_s && wr_last_s) begin
                    next_state_s = ST_READ;
                end else begin
                    next_state_s = ST_WRITE;
                end
            end
            ST_READ: begin
                // Stay until the final output beat is on the port, so busy
                // drops the cycle after out_last.
                if (out_last_r) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_READ;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Configuration, divider and address counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_r       <= 17'd0;
            qm_r      <= 3'd0;
            quot_r    <= 17'd0;
            div_q_r   <= 17'd0;
            div_rem_r <= 3'd0;
            div_cnt_r <= 5'd0;
            wr_i_r    <= 3'd0;
            wr_j_r    <= 17'd0;
            wr_addr_r <= 17'd0;
            wr_cnt_r  <= 17'd0;
            rd_addr_r <= 17'd0;
            rd_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wr_i_r    <= 3'd0;
                    wr_j_r    <= 17'd0;
                    wr_addr_r <= 17'd0;
                    wr_cnt_r  <= 17'd0;
                    rd_addr_r <= 17'd0;
                    rd_done_r <= 1'b0;
                    if (start && cfg_ok_s) begin
                        e_r       <= E;
                        qm_r      <= Qm;
                        div_q_r   <= E;
                        div_rem_r <= 3'd0;
                        div_cnt_r <= 5'd0;
                    end
                end
                ST_DIV: begin
                    div_q_r   <= q_next_s;
                    div_rem_r <= rem_next_s;
                    div_cnt_r <= div_cnt_r + 5'd1;
                    if (div_last_s) begin
                        quot_r <= q_next_s;
                    end
                end
                ST_WRITE: begin
                    if (wr_fire_s) begin
                        wr_cnt_r <= wr_cnt_r + 17'd1;
                        // Address i*R + j built by stepping R per row; a
                        // column wrap restarts at the new j.
                        if (wr_i_r < (qm_r - 3'd1)) begin
                            wr_i_r    <= wr_i_r + 3'd1;
                            wr_addr_r <= wr_addr_r + quot_r;
                        end else begin
                            wr_i_r    <= 3'd0;
                            wr_j_r    <= wr_j_r + 17'd1;
                            wr_addr_r <= wr_j_r + 17'd1;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_en_s) begin
                        rd_addr_r <= rd_addr_r + 17'd1;
                        rd_done_r <= (rd_addr_r == (e_r - 17'd1));
                    end
                end
                default: begin
                    rd_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered handshake, status and output-data ports.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_llr_r   <= '0;
        end else begin
            in_ready_r  <= (next_state_s == ST_WRITE);
            busy_r      <= (next_state_s != ST_IDLE);
            err_r       <= ((state_r == ST_IDLE) && start && !cfg_ok_s) ||
                           ((state_r == ST_DIV) && div_last_s && (rem_next_s != 3'd0));
            out_valid_r <= rd_en_s;
            out_last_r  <= rd_en_s && (rd_addr_r == (e_r - 17'd1));
            if (rd_en_s) begin
                out_llr_r <= mem[rd_addr_r];
            end
        end
    end

    // Buffer write port; contents need no reset since every read address
    // of a codeword is written before the read phase begins.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem[wr_addr_r] <= in_llr;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_llr   = out_llr_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: tb/tb_pusch_bit_deinterleaver.sv
`timescale 1ns/1ps
module tb_pusch_bit_deinterleaver;

    localparam int LLR_W    = 8;
    localparam int MAX_E_TB = 120;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [16:0]      E;
    logic [2:0]       Qm;
    logic             in_valid;
    logic [LLR_W-1:0] in_llr;
    logic             in_ready;
    logic             out_valid;
    logic [LLR_W-1:0] out_llr;
    logic             out_last;
    logic             busy;
    logic             err;

    always #5 clk = ~clk;

    pusch_bit_deinterleaver #(.LLR_W(LLR_W), .MAX_E(MAX_E_TB)) dut (
        .clk(clk), .reset(reset), .start(start), .E(E), .Qm(Qm),
        .in_valid(in_valid), .in_llr(in_llr), .in_ready(in_ready),
        .out_valid(out_valid), .out_llr(out_llr), .out_last(out_last),
        .busy(busy), .err(err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [LLR_W-1:0] f_a   [0:MAX_E_TB-1];
    logic [LLR_W-1:0] exp_a [0:MAX_E_TB-1];

    typedef struct {
        logic [2:0]  qm;
        logic [16:0] e;
        int          err_cyc;
        int          busy_cycles;
    } cfg_vec_t;

    cfg_vec_t cfg_tab [8];

    int exp8  [8]  = '{0, 2, 4, 6, 1, 3, 5, 7};
    int exp12 [12] = '{0, 6, 1, 7, 2, 8, 3, 9, 4, 10, 5, 11};
    int exp16 [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    int in5   [5]  = '{-3, 7, 0, 127, -128};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " in_ready"},  {31'd0, in_ready},  32'd0);
        chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " out_llr"},   {24'd0, out_llr},   32'd0);
        chk({tag, " out_last"},  {31'd0, out_last},  32'd0);
        chk({tag, " busy"},      {31'd0, busy},      32'd0);
        chk({tag, " err"},       {31'd0, err},       32'd0);
    endtask

    // Configuration vector: error timing, busy duration, no in_ready.
    task automatic run_cfg(input int idx);
        int err_at = -1;
        int err_n  = 0;
        int busy_n = 0;
        int rdy_n  = 0;
        @(negedge clk);
        start = 1'b1; Qm = cfg_tab[idx].qm; E = cfg_tab[idx].e;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (err) begin
                err_n++;
                if (err_at < 0) err_at = c;
            end
            if (busy) busy_n++;
            if (in_ready) rdy_n++;
        end
        chk($sformatf("cfg%0d err_cycle", idx), err_at, cfg_tab[idx].err_cyc);
        chk($sformatf("cfg%0d err_pulses", idx), err_n, 32'd1);
        chk($sformatf("cfg%0d busy_cycles", idx), busy_n, cfg_tab[idx].busy_cycles);
        chk($sformatf("cfg%0d in_ready_cycles", idx), rdy_n, 32'd0);
    endtask

    // Full codeword: f_a in, exp_a expected out.
    task automatic run_cw(input int qm, input int e, input bit gap, input bit starts, input string tag);
        int  k = 0, n = 0, w = -1, c = 0;
        int  first_rdy = -1, first_ov = -1, last_ov = -1, ov_n = 0;
        int  overlap = 0, bad_last = 0;
        bit  done = 1'b0;
        @(negedge clk);
        start = 1'b1; Qm = qm[2:0]; E = e[16:0];
        while (!done && c < 60 + 3 * e) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (in_ready && first_rdy < 0) first_rdy = c;
            if (in_ready && out_valid) overlap++;
            if (out_valid) begin
                ov_n++;
                if (first_ov < 0) first_ov = c;
                last_ov = c;
                if (n < e) begin
                    chk($sformatf("%s out_llr[%0d]", tag, n), {24'd0, out_llr}, {24'd0, exp_a[n]});
                    chk($sformatf("%s out_last[%0d]", tag, n), {31'd0, out_last}, (n == e - 1) ? 32'd1 : 32'd0);
                end
                n++;
            end else if (out_last) begin
                bad_last++;
            end
            if (w >= 0 && c == w + e + 1) chk({tag, " busy_at_last"}, {31'd0, busy}, 32'd1);
            if (w >= 0 && c == w + e + 2) begin
                chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
                done = 1'b1;
            end
            if (in_ready && k < e && (!gap || (c % 2 == 0))) begin
                in_valid = 1'b1; in_llr = f_a[k]; k++;
                if (k == e) w = c;
            end else if (!in_ready) begin
                in_valid = 1'b1; in_llr = 8'h5A;
            end else begin
                in_valid = 1'b0;
            end
            if (starts && (c == 5 || c == 30 || (w >= 0 && c == w + 4))) begin
                start = 1'b1; E = 17'd4; Qm = 3'd2;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk({tag, " completed"}, {31'd0, done}, 32'd1);
        chk({tag, " first_in_ready"}, first_rdy, 32'd18);
        chk({tag, " first_out_valid"}, first_ov, w + 2);
        chk({tag, " last_out_valid"}, last_ov, w + e + 1);
        chk({tag, " out_valid_count"}, ov_n, e);
        chk({tag, " ready_valid_overlap"}, overlap, 32'd0);
        chk({tag, " stray_out_last"}, bad_last, 32'd0);
    endtask

    initial begin
        int k;
        int r;
        reset = 1'b1; start = 1'b0; E = 17'd0; Qm = 3'd0; in_valid = 1'b0; in_llr = '0;

        cfg_tab[0] = '{3'd3, 17'd12,  1,  0};
        cfg_tab[1] = '{3'd4, 17'd10, 18, 17};
        cfg_tab[2] = '{3'd0, 17'd8,   1,  0};
        cfg_tab[3] = '{3'd2, 17'd0,   1,  0};
        cfg_tab[4] = '{3'd2, 17'd121, 1,  0};
        cfg_tab[5] = '{3'd6, 17'd13, 18, 17};
        cfg_tab[6] = '{3'd5, 17'd10,  1,  0};
        cfg_tab[7] = '{3'd7, 17'd14,  1,  0};

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset_held");
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("after_reset");

        for (int i = 0; i < 8; i++) run_cfg(i);

        // Qm=2, E=8 back-to-back.
        for (int i = 0; i < 8; i++) begin
            f_a[i] = 8'(i); exp_a[i] = 8'(exp8[i]);
        end
        run_cw(2, 8, 1'b0, 1'b0, "qm2_e8");

        // Qm=6, E=12 with input gaps.
        for (int i = 0; i < 12; i++) begin
            f_a[i] = 8'(i); exp_a[i] = 8'(exp12[i]);
        end
        run_cw(6, 12, 1'b1, 1'b0, "qm6_e12_gap");

        // Qm=1, E=5: identity, signed extremes.
        for (int i = 0; i < 5; i++) begin
            f_a[i] = 8'(in5[i]); exp_a[i] = 8'(in5[i]);
        end
        run_cw(1, 5, 1'b0, 1'b0, "qm1_e5");

        // Reset after 9 accepted inputs of a Qm=4, E=16 codeword.
        @(negedge clk);
        start = 1'b1; Qm = 3'd4; E = 17'd16;
        k = 0;
        for (int c = 1; c < 100 && k < 9; c++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b0;
            if (in_ready) begin
                in_valid = 1'b1; in_llr = 8'(k + 100); k++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_reset busy", {31'd0, busy}, 32'd1);
        chk("pre_reset in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        #1;
        chk_idle_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            f_a[i] = 8'(i); exp_a[i] = 8'(exp16[i]);
        end
        run_cw(4, 16, 1'b0, 1'b0, "qm4_e16_after_reset");

        // Qm=6, E=MAX_E random data, stray start pulses in every phase.
        r = MAX_E_TB / 6;
        for (int i = 0; i < MAX_E_TB; i++) f_a[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < r; j++) exp_a[i * r + j] = f_a[i + j * 6];
        end
        run_cw(6, MAX_E_TB, 1'b0, 1'b1, "qm6_max_e");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
